button_debounce: RTL and testbench
==================================

# button_debounce

Input conditioner for a raw push-button pin. It sits between the board-level button pad and any logic that consumes button events (mode selection, blinky control). It synchronizes the asynchronous pin and filters contact bounce with a consecutive-sample counter. It produces a clean level plus single-cycle press, release and long-press event pulses, and all outputs are in the `clk_i` domain.

## Interface
- `DebounceCycles`, default 500000: consecutive stable synchronized samples required before the debounced level changes; must be ≥ 1.
- `LongPressCycles`, default 50000000: cycles `level_o` must stay high before a long-press event; must be ≥ 1.
- `ActiveLow`, default 1: 1 means `btn_i` = 0 is "pressed" (board buttons are active-low); 0 means `btn_i` = 1 is "pressed".
- `clk_i` input 1: system clock. One clock; all logic is on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `btn_i` input 1: raw button pin, asynchronous to `clk_i`.
- `level_o` output 1: debounced pressed state; 1 = pressed.
- `press_o` output 1: one-cycle pulse on the first cycle `level_o` is 1.
- `release_o` output 1: one-cycle pulse on the first cycle `level_o` is 0 after being 1.
- `long_press_o` output 1: one-cycle pulse when the press has lasted `LongPressCycles` cycles; at most once per press.
- `held_o` output 1: 1 from the `long_press_o` cycle until release.

## Operation
- **Synchronizer:** two flops on `btn_i`. Both reset to the inactive raw level: 1 if `ActiveLow`, else 0.
- **Normalized input:** `p` = synchronized value XOR `ActiveLow`, so `p` = 1 means pressed.
- **Debounce counter:**
  - Width is `$clog2(DebounceCycles+1)`.
  - It counts consecutive cycles where `p` ≠ `level_o`.
  - Any cycle with `p` = `level_o` clears it to 0, which rejects glitches shorter than `DebounceCycles`.
  - When the counter equals `DebounceCycles`-1 and `p` ≠ `level_o`, the next edge toggles `level_o` and clears the counter.
- **FSM states:**
  - RELEASED: `level_o`=0.
  - PRESSED: `level_o`=1, `held_o`=0.
  - HELD: `level_o`=1, `held_o`=1.
- **FSM transitions:**
  - RELEASED→PRESSED on debounced rise; `press_o`=1 in the first PRESSED cycle.
  - PRESSED→HELD when the hold counter expires; `long_press_o`=1 in the first HELD cycle.
  - PRESSED→RELEASED or HELD→RELEASED on debounced fall; `release_o`=1 in the first RELEASED cycle.
- **Hold counter:**
  - Width is `$clog2(LongPressCycles+1)`.
  - It is cleared on entry to PRESSED and increments each PRESSED cycle.
  - On reaching `LongPressCycles`-1 it moves the FSM to HELD on the next edge.
  - It is frozen in HELD and RELEASED, so there is no wrap and no repeat pulse.
- **Simultaneous events:** a debounced fall in the same cycle the hold counter expires takes priority. The FSM goes to RELEASED, `release_o` pulses, and `long_press_o` does not pulse.
- **Pulse exclusivity:** at most one of `press_o`, `release_o`, `long_press_o` is high in any cycle.
- **Reset values:** all outputs 0, state RELEASED, both counters 0, synchronizer at the inactive level.
- **Reset asserted mid-press:** everything returns to reset values immediately (asynchronous). No `release_o` is emitted.
- **Button held through reset release:** it is treated as a new press, so `press_o` fires after normal debounce latency.

## Timing
- **Press/release latency:** label as edge 1 the rising edge where the first synchronizer flop samples a stable change of `btn_i`.
  - `level_o` and the corresponding pulse become visible after edge `DebounceCycles`+2.
  - Example: `DebounceCycles`=1 gives 3 edges.
- **Minimum accepted pulse:** `btn_i` must hold the new level for at least `DebounceCycles` sampled cycles to be accepted.
- **Long-press timing:** if `press_o` is high in cycle P, `long_press_o` is high in cycle P+`LongPressCycles`, provided `level_o` stayed 1 through that cycle.
- **Pulse width:** all event pulses are exactly 1 cycle wide.
- **Outputs:** all registered, with no combinational path from `btn_i`.

## Test plan
- **Clean press:** parameters `DebounceCycles`=4, `LongPressCycles`=10, `ActiveLow`=1. Drive `btn_i` 1→0 before edge 1 and hold. Required: `level_o` and `press_o` rise after edge 6; `press_o` low after edge 7.
- **Bounce rejection:** same parameters. `btn_i` goes 0 for 3 cycles, 1 for 2, then 0 for 3, then back to 1. Required: `level_o`, `press_o` and `release_o` stay 0 throughout.
- **Long press:** hold pressed 20 cycles after `press_o` in cycle P. Required: `long_press_o` pulses only in cycle P+10; `held_o`=1 from P+10 until the release is debounced; exactly one `release_o` at release.
- **Short press:** press held so `level_o` is high 6 cycles, then released. Required: `press_o` once, `release_o` once; `long_press_o` and `held_o` never assert.
- **Expiry vs. release collision:** time the release so the debounced fall coincides with hold counter expiry. Required: `release_o`=1 and `long_press_o`=0.
- **Reset mid-hold:** assert `rst_ni`=0 while in HELD, then release reset with the button still pressed. Required: all outputs 0 during reset with no `release_o`; after reset, `press_o` fires again 6 edges after the first post-reset sample.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: conditions a raw push-button pin into a clean pressed level
// plus single-cycle press, release and long-press event pulses in the clk_i domain.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_RELEASED | debounced level low, waiting for a debounced rise
// ST_PRESSED  | level high, hold counter running toward long-press
// ST_HELD     | level high, long-press already reported, waiting for fall
module button_debounce #(
  parameter int DebounceCycles  = 500000,
  parameter int LongPressCycles = 50000000,
  parameter bit ActiveLow       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic held_o
);

  localparam int DbW   = $clog2(DebounceCycles + 1);
  localparam int HoldW = $clog2(LongPressCycles + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressCycles - 1);

  // Raw pin level meaning "not pressed"; the synchronizer idles here.
  localparam logic InactiveRaw = ActiveLow;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [DbW-1:0]   r_db_cnt;
  logic [HoldW-1:0] r_hold_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_held;

  logic w_p;
  logic w_toggle;
  logic w_rise;
  logic w_fall;

  // Two-flop synchronizer on the asynchronous button pin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= InactiveRaw;
      r_sync2 <= InactiveRaw;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  // Normalized pressed sample and debounced edge detection.
  assign w_p      = r_sync2 ^ ActiveLow;
  assign w_toggle = (w_p != r_level) && (r_db_cnt == DbLast);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db_cnt <= '0;
    end else if ((w_p == r_level) || w_toggle) begin
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Press/hold/release FSM with registered level, held flag and event pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RELEASED;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_rise) begin
            r_state    <= ST_PRESSED;
            r_level    <= 1'b1;
            r_press    <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          // A debounced fall wins over a simultaneous hold expiry.
          if (w_fall) begin
            r_state   <= ST_RELEASED;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else if (r_hold_cnt == HoldLast) begin
            r_state <= ST_HELD;
            r_held  <= 1'b1;
            r_long  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            r_state   <= ST_RELEASED;
            r_level   <= 1'b0;
            r_held    <= 1'b0;
            r_release <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RELEASED;
          r_level <= 1'b0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign level_o      = r_level;
  assign press_o      = r_press;
  assign release_o    = r_release;
  assign long_press_o = r_long;
  assign held_o       = r_held;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DebounceCycles=4, LongPressCycles=10,
// ActiveLow=1. Inputs change 1 ns after a rising edge; outputs are sampled there.
module tb_button_debounce;

  logic clk_i;
  logic rst_ni;
  logic btn_i;
  logic level_o;
  logic press_o;
  logic release_o;
  logic long_press_o;
  logic held_o;

  int n_tests;
  int n_fail;

  button_debounce #(
    .DebounceCycles (4),
    .LongPressCycles(10),
    .ActiveLow      (1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .btn_i       (btn_i),
    .level_o     (level_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_press_o(long_press_o),
    .held_o      (held_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    btn_i  = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=00000",
               {level_o, press_o, release_o, long_press_o, held_o});
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc=%0d got=%b want=00000", i,
                 {level_o, press_o, release_o, long_press_o, held_o});
      end
    end
  endtask

  // Press then hold 20 cycles past P; long-press at P+10, then debounced release.
  task automatic test_clean_and_long_press();
    int n_rel;
    btn_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_tests++;
      if (level_o !== 1'b0 || press_o !== 1'b0) begin
        n_fail++;
        $display("FAIL press_early edge=%0d level=%b press=%b want 0 0", e, level_o, press_o);
      end
    end
    tick();
    n_tests++;
    if (level_o !== 1'b1 || press_o !== 1'b1) begin
      n_fail++;
      $display("FAIL press_edge6 level=%b press=%b want 1 1", level_o, press_o);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_tests++;
      if (press_o !== 1'b0 || level_o !== 1'b1 || long_press_o !== (k == 10) ||
          held_o !== (k >= 10) || release_o !== 1'b0) begin
        n_fail++;
        $display("FAIL long_press P+%0d lvl=%b prs=%b lng=%b hld=%b rel=%b want lng=%b hld=%b",
                 k, level_o, press_o, long_press_o, held_o, release_o, (k == 10), (k >= 10));
      end
    end
    btn_i = 1'b1;
    n_rel = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (release_o === 1'b1) n_rel++;
      n_tests++;
      if (level_o !== (e < 6) || held_o !== (e < 6) || release_o !== (e == 6) ||
          long_press_o !== 1'b0) begin
        n_fail++;
        $display("FAIL long_release edge=%0d lvl=%b hld=%b rel=%b lng=%b want lvl=%b hld=%b rel=%b",
                 e, level_o, held_o, release_o, long_press_o, (e < 6), (e < 6), (e == 6));
      end
    end
    n_tests++;
    if (n_rel != 1) begin
      n_fail++;
      $display("FAIL long_release_count got=%0d want=1", n_rel);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] pattern;
    // Bits consumed LSB first: 0 x3, 1 x2, 0 x3, then 1.
    pattern = 16'b1111_1111_0001_1000;
    for (int i = 0; i < 16; i++) begin
      btn_i = pattern[i];
      tick();
      n_tests++;
      if (level_o !== 1'b0 || press_o !== 1'b0 || release_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce cyc=%0d lvl=%b prs=%b rel=%b want 000", i, level_o, press_o, release_o);
      end
    end
  endtask

  task automatic test_short_press();
    int n_press, n_rel, n_long, n_held, n_lvl;
    n_press = 0; n_rel = 0; n_long = 0; n_held = 0; n_lvl = 0;
    btn_i = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (press_o === 1'b1) n_press++;
      if (level_o === 1'b1) n_lvl++;
    end
    btn_i = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (press_o === 1'b1) n_press++;
      if (release_o === 1'b1) n_rel++;
      if (long_press_o === 1'b1) n_long++;
      if (held_o === 1'b1) n_held++;
      if (level_o === 1'b1) n_lvl++;
    end
    n_tests++;
    if (n_press != 1 || n_rel != 1 || n_long != 0 || n_held != 0 || n_lvl != 6) begin
      n_fail++;
      $display("FAIL short_press press=%0d rel=%0d long=%0d held=%0d lvl_cycles=%0d want 1 1 0 0 6",
               n_press, n_rel, n_long, n_held, n_lvl);
    end
  endtask

  // Release timed so the debounced fall lands on the hold-expiry edge (P+9 -> P+10).
  task automatic test_collision();
    btn_i = 1'b0;
    for (int e = 1; e <= 6; e++) tick();
    n_tests++;
    if (press_o !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_press got=%b want=1", press_o);
    end
    for (int k = 1; k <= 4; k++) tick();
    btn_i = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_tests++;
      if (level_o !== 1'b1 || long_press_o !== 1'b0 || held_o !== 1'b0 || release_o !== 1'b0) begin
        n_fail++;
        $display("FAIL collision_pre edge=%0d lvl=%b lng=%b hld=%b rel=%b want 1000",
                 e, level_o, long_press_o, held_o, release_o);
      end
    end
    tick();
    n_tests++;
    if (release_o !== 1'b1 || long_press_o !== 1'b0 || level_o !== 1'b0 || held_o !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_edge rel=%b lng=%b lvl=%b hld=%b want 1000",
               release_o, long_press_o, level_o, held_o);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL collision_after cyc=%0d got=%b want=00000", k,
                 {level_o, press_o, release_o, long_press_o, held_o});
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    btn_i = 1'b0;
    for (int e = 1; e <= 6 + 12; e++) tick();
    n_tests++;
    if (held_o !== 1'b1 || level_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_hold_setup held=%b level=%b want 1 1", held_o, level_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_async got=%b want=00000",
               {level_o, press_o, release_o, long_press_o, held_o});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_during cyc=%0d got=%b want=00000", k,
                 {level_o, press_o, release_o, long_press_o, held_o});
      end
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_tests++;
      if ({level_o, press_o, release_o, long_press_o, held_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_repress_early edge=%0d got=%b want=00000", e,
                 {level_o, press_o, release_o, long_press_o, held_o});
      end
    end
    tick();
    n_tests++;
    if (press_o !== 1'b1 || level_o !== 1'b1 || release_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_repress_edge6 prs=%b lvl=%b rel=%b want 1 1 0", press_o, level_o, release_o);
    end
    btn_i = 1'b1;
    for (int e = 1; e <= 8; e++) tick();
    n_tests++;
    if (level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_final_release level=%b want 0", level_o);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clean_and_long_press();
    test_bounce();
    test_short_press();
    test_collision();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
